// File: rtl/mips_cpu_muldiv_if.sv
// mips_cpu_muldiv_if
//   Request/result bundle between pipeline control and the HI/LO
//   multiply/divide unit.
//   start  : request strobe, sampled only while busy=0
//   op     : 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved
//   a, b   : operands from regfile read ports rs / rt
//   cancel : abort in-flight op, also rejects a same-cycle start
//   busy   : op in flight, HI/LO not yet updated
//   done   : one-cycle pulse after a mul/div op writes HI/LO
//   hi, lo : architectural HI/LO registers
interface mips_cpu_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, a, b, cancel,
                    input  busy, done, hi, lo);
    modport slave  (input  start, op, a, b, cancel,
                    output busy, done, hi, lo);
endinterface

// File: rtl/mips_cpu_muldiv.sv
// mips_cpu_muldiv
//   Multi-cycle HI/LO multiply/divide unit. MULT/MULTU use radix-2
//   shift-add (or a single product step when FAST_MUL=1), DIV/DIVU use
//   restoring division of operand magnitudes with a final sign fix-up.
//   MTHI/MTLO write HI/LO directly on the accept edge.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : slave side of mips_cpu_muldiv_if (start/op/a/b/cancel in,
//         busy/done/hi/lo out)
module mips_cpu_muldiv #(
    parameter int WIDTH    = 32,
    parameter bit FAST_MUL = 1'b0
) (
    input logic               clk,
    input logic               rst,
    mips_cpu_muldiv_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINAL} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;      // mul: {partial, multiplier}; div: {rem, quotient}
    logic [WIDTH-1:0]   r_opnd;     // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   r_a_raw;    // unmodified dividend, returned in HI on divide by zero
    logic               r_is_div;
    logic               r_neg_q;    // product / quotient sign
    logic               r_neg_r;    // remainder sign
    logic               r_div0;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    logic               w_accept;
    logic               w_md_op;
    logic               w_signed;
    logic               w_div;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_fin_hi;
    logic [WIDTH-1:0]   w_fin_lo;

    assign w_accept = (r_state == S_IDLE) && bus.start && !bus.cancel;
    assign w_md_op  = !bus.op[2];
    assign w_signed = !bus.op[0];
    assign w_div    = bus.op[1];
    assign w_a_mag  = (w_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign w_b_mag  = (w_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    // Shift-add: add multiplicand into the upper half when the current
    // multiplier LSB is set, then shift the whole accumulator right.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring divide: the top bit of the WIDTH+1 difference is the borrow.
    assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_diff     = w_rem_sh - {1'b0, r_opnd};
    assign w_div_next = {(w_diff[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_diff[WIDTH-1:0]),
                         r_acc[WIDTH-2:0], !w_diff[WIDTH]};

    always_comb begin
        w_fin_hi = '0;
        w_fin_lo = '0;
        w_prod   = r_neg_q ? -r_acc : r_acc;
        if (r_is_div) begin
            if (r_div0) begin
                w_fin_hi = r_a_raw;
                w_fin_lo = '1;
            end else begin
                w_fin_hi = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
                w_fin_lo = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
            end
        end else begin
            {w_fin_hi, w_fin_lo} = w_prod;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_md_op)
                    w_state_nxt = (FAST_MUL && !w_div) ? S_FINAL : S_RUN;
            end
            S_RUN: begin
                if (bus.cancel)
                    w_state_nxt = S_IDLE;
                else if (r_cnt == '0)
                    w_state_nxt = S_FINAL;
            end
            S_FINAL: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_a_raw  <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= (r_state == S_FINAL) && !bus.cancel;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_md_op) begin
                            r_cnt    <= CW'(WIDTH-1);
                            r_is_div <= w_div;
                            r_neg_q  <= w_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                            r_neg_r  <= w_signed && bus.a[WIDTH-1];
                            r_div0   <= (bus.b == '0);
                            r_a_raw  <= bus.a;
                            r_opnd   <= w_div ? w_b_mag : w_a_mag;
                            if (w_div)
                                r_acc <= {{WIDTH{1'b0}}, w_a_mag};
                            else if (FAST_MUL)
                                r_acc <= (2*WIDTH)'(w_a_mag) * (2*WIDTH)'(w_b_mag);
                            else
                                r_acc <= {{WIDTH{1'b0}}, w_b_mag};
                        end else if (bus.op == 3'd4) begin
                            r_hi <= bus.a;
                        end else if (bus.op == 3'd5) begin
                            r_lo <= bus.a;
                        end
                    end
                end
                S_RUN: begin
                    if (!bus.cancel) begin
                        r_acc <= r_is_div ? w_div_next : w_mul_next;
                        if (r_cnt != '0)
                            r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_FINAL: begin
                    if (!bus.cancel) begin
                        r_hi <= w_fin_hi;
                        r_lo <= w_fin_lo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (r_state != S_IDLE);
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule

// File: tb/tb_mips_cpu_muldiv.sv
module tb_mips_cpu_muldiv;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mips_cpu_muldiv_if #(.WIDTH(W)) if_s ();
    mips_cpu_muldiv_if #(.WIDTH(W)) if_f ();

    mips_cpu_muldiv #(.WIDTH(W), .FAST_MUL(1'b0)) u_slow (.clk(clk), .rst(rst), .bus(if_s));
    mips_cpu_muldiv #(.WIDTH(W), .FAST_MUL(1'b1)) u_fast (.clk(clk), .rst(rst), .bus(if_f));

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [63:0] exp;
        int          due;
    } ent_t;
    ent_t q_s[$];
    ent_t q_f[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitors: every done pulse must match the oldest expected entry.
    always @(posedge clk) begin : mon_s
        ent_t e;
        #1;
        if (if_s.done === 1'b1) begin
            n_tests++;
            if (q_s.size() == 0) begin
                n_fail++;
                $display("FAIL slow_unexpected_done: done=1 required 0 at cycle %0d", cyc);
            end else begin
                e = q_s.pop_front();
                if ({if_s.hi, if_s.lo} !== e.exp) begin
                    n_fail++;
                    $display("FAIL slow_result: hi:lo=%h required %h", {if_s.hi, if_s.lo}, e.exp);
                end
                n_tests++;
                if (cyc !== e.due) begin
                    n_fail++;
                    $display("FAIL slow_latency: done at cycle %0d required %0d", cyc, e.due);
                end
            end
        end
    end

    always @(posedge clk) begin : mon_f
        ent_t e;
        #1;
        if (if_f.done === 1'b1) begin
            n_tests++;
            if (q_f.size() == 0) begin
                n_fail++;
                $display("FAIL fast_unexpected_done: done=1 required 0 at cycle %0d", cyc);
            end else begin
                e = q_f.pop_front();
                if ({if_f.hi, if_f.lo} !== e.exp) begin
                    n_fail++;
                    $display("FAIL fast_result: hi:lo=%h required %h", {if_f.hi, if_f.lo}, e.exp);
                end
                n_tests++;
                if (cyc !== e.due) begin
                    n_fail++;
                    $display("FAIL fast_latency: done at cycle %0d required %0d", cyc, e.due);
                end
            end
        end
    end

    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic signed [31:0] q, r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        model = '0;
        case (op)
            3'd0: model = sa * sb;
            3'd1: model = {32'b0, a} * {32'b0, b};
            3'd2: begin
                if (b == 32'd0)                                model = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = {32'd0, a};
                else begin
                    q = $signed(a) / $signed(b);
                    r = $signed(a) % $signed(b);
                    model = {r, q};
                end
            end
            3'd3: model = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            default: model = '0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input int d, input logic st, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic cn);
        if (d == 0) begin
            if_s.start = st; if_s.op = op; if_s.a = a; if_s.b = b; if_s.cancel = cn;
        end else begin
            if_f.start = st; if_f.op = op; if_f.a = a; if_f.b = b; if_f.cancel = cn;
        end
    endtask

    // Issue an op on an idle DUT and record its expected result and done cycle.
    task automatic issue(input int d, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int lat);
        ent_t e;
        e.exp = exp;
        e.due = cyc + 1 + lat;
        if (d == 0) q_s.push_back(e); else q_f.push_back(e);
        drive(d, 1'b1, op, a, b, 1'b0);
        tick();
        drive(d, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic wait_empty(input int d, input string tag);
        int n;
        n = 0;
        while (((d == 0) ? q_s.size() : q_f.size()) != 0 && n < 60) begin
            tick();
            n++;
        end
        n_tests++;
        if (((d == 0) ? q_s.size() : q_f.size()) != 0) begin
            n_fail++;
            $display("FAIL %s_timeout: no result after %0d cycles, required within 60", tag, n);
            if (d == 0) q_s.delete(); else q_f.delete();
        end
    endtask

    task automatic test_reset();
        drive(0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        drive(1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        n_tests++;
        if ({if_s.busy, if_s.done, if_s.hi, if_s.lo} !== 66'd0) begin
            n_fail++;
            $display("FAIL reset_slow: busy/done/hi/lo=%h required 0", {if_s.busy, if_s.done, if_s.hi, if_s.lo});
        end
        n_tests++;
        if ({if_f.busy, if_f.done, if_f.hi, if_f.lo} !== 66'd0) begin
            n_fail++;
            $display("FAIL reset_fast: busy/done/hi/lo=%h required 0", {if_f.busy, if_f.done, if_f.hi, if_f.lo});
        end
    endtask

    task automatic test_mul();
        issue(0, 3'd0, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 33);
        n_tests++;
        if (if_s.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mul_busy: busy=%b required 1", if_s.busy);
        end
        repeat (10) tick();
        n_tests++;
        if ({if_s.hi, if_s.lo} !== 64'd0) begin
            n_fail++;
            $display("FAIL mul_hold_during_run: hi:lo=%h required 0", {if_s.hi, if_s.lo});
        end
        wait_empty(0, "mult");
        tick();
        n_tests++;
        if (if_s.done !== 1'b0 || if_s.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mul_done_pulse: done=%b busy=%b required 0 0", if_s.done, if_s.busy);
        end
        issue(0, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 33);
        wait_empty(0, "multu");
    endtask

    task automatic test_mul_fast();
        issue(1, 3'd0, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 1);
        wait_empty(1, "fast_mult");
        issue(1, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1);
        wait_empty(1, "fast_multu");
        issue(1, 3'd2, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33);
        wait_empty(1, "fast_div");
    endtask

    task automatic test_div();
        issue(0, 3'd2, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33);
        wait_empty(0, "div");
        issue(0, 3'd3, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
        wait_empty(0, "divu");
        issue(0, 3'd3, 32'd100, 32'd0, {32'h0000_0064, 32'hFFFF_FFFF}, 33);
        wait_empty(0, "divu_by_zero");
        issue(0, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33);
        wait_empty(0, "div_overflow");
        issue(0, 3'd2, 32'hFFFF_FFF0, 32'd0, {32'hFFFF_FFF0, 32'hFFFF_FFFF}, 33);
        wait_empty(0, "div_by_zero");
    endtask

    task automatic test_mthi_cancel();
        logic [31:0] lo_prev;
        drive(0, 1'b1, 3'd4, 32'h1234_5678, 32'd0, 1'b0);
        tick();
        drive(0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        n_tests++;
        if (if_s.hi !== 32'h1234_5678 || if_s.busy !== 1'b0 || if_s.done !== 1'b0) begin
            n_fail++;
            $display("FAIL mthi: hi=%h busy=%b done=%b required 12345678 0 0", if_s.hi, if_s.busy, if_s.done);
        end
        lo_prev = if_s.lo;
        drive(0, 1'b1, 3'd5, 32'hDEAD_BEEF, 32'd0, 1'b1);
        tick();
        drive(0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        n_tests++;
        if (if_s.lo !== lo_prev) begin
            n_fail++;
            $display("FAIL mtlo_cancel_rejected: lo=%h required %h", if_s.lo, lo_prev);
        end
        drive(0, 1'b1, 3'd6, 32'hCAFE_0000, 32'd1, 1'b0);
        tick();
        drive(0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        n_tests++;
        if (if_s.busy !== 1'b0 || if_s.hi !== 32'h1234_5678 || if_s.lo !== lo_prev) begin
            n_fail++;
            $display("FAIL reserved_op: busy=%b hi=%h lo=%h required 0 12345678 %h", if_s.busy, if_s.hi, if_s.lo, lo_prev);
        end
        // MULT 2*3 cancelled ten RUN edges in: nothing queued, so any done is flagged.
        drive(0, 1'b1, 3'd0, 32'd2, 32'd3, 1'b0);
        tick();
        drive(0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        repeat (9) tick();
        n_tests++;
        if (if_s.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL cancel_pre_busy: busy=%b required 1", if_s.busy);
        end
        drive(0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        tick();
        drive(0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        n_tests++;
        if (if_s.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL cancel_busy: busy=%b required 0", if_s.busy);
        end
        repeat (40) tick();
        n_tests++;
        if (if_s.hi !== 32'h1234_5678 || if_s.lo !== lo_prev) begin
            n_fail++;
            $display("FAIL cancel_retain: hi=%h lo=%h required 12345678 %h", if_s.hi, if_s.lo, lo_prev);
        end
        // Start while busy must be ignored; only the MULT result may appear.
        issue(0, 3'd0, 32'd2, 32'd3, 64'd6, 33);
        repeat (5) tick();
        drive(0, 1'b1, 3'd3, 32'd100, 32'd7, 1'b0);
        tick();
        drive(0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        wait_empty(0, "start_while_busy");
        repeat (40) tick();
        n_tests++;
        if (if_s.busy !== 1'b0 || {if_s.hi, if_s.lo} !== 64'd6) begin
            n_fail++;
            $display("FAIL ignored_start: busy=%b hi:lo=%h required 0 6", if_s.busy, {if_s.hi, if_s.lo});
        end
    endtask

    task automatic test_back_to_back();
        int n;
        ent_t e;
        issue(0, 3'd3, 32'd9, 32'd4, {32'd1, 32'd2}, 33);
        n = 0;
        while (if_s.done !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        n_tests++;
        if (if_s.done !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first_timeout: no done after %0d cycles, required within 60", n);
            q_s.delete();
        end
        e.exp = 64'd25;
        e.due = cyc + 1 + 33;
        q_s.push_back(e);
        drive(0, 1'b1, 3'd1, 32'd5, 32'd5, 1'b0);
        tick();
        drive(0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        n_tests++;
        if (if_s.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_accept: busy=%b required 1", if_s.busy);
        end
        wait_empty(0, "b2b_second");
    endtask

    task automatic test_reset_midrun();
        drive(0, 1'b1, 3'd1, 32'd7, 32'd9, 1'b0);
        tick();
        drive(0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        repeat (5) tick();
        n_tests++;
        if (if_s.busy !== 1'b1 || if_s.lo === 32'd0) begin
            n_fail++;
            $display("FAIL pre_reset: busy=%b lo=%h required 1 and nonzero", if_s.busy, if_s.lo);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if ({if_s.busy, if_s.done, if_s.hi, if_s.lo} !== 66'd0) begin
            n_fail++;
            $display("FAIL async_reset: busy/done/hi/lo=%h required 0", {if_s.busy, if_s.done, if_s.hi, if_s.lo});
        end
        repeat (2) tick();
        rst = 1'b1;
        repeat (40) tick();
        n_tests++;
        if (if_s.busy !== 1'b0 || {if_s.hi, if_s.lo} !== 64'd0) begin
            n_fail++;
            $display("FAIL post_reset: busy=%b hi:lo=%h required 0 0", if_s.busy, {if_s.hi, if_s.lo});
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 12; i++) begin
            op = 3'($urandom_range(0, 3));
            a  = $urandom();
            b  = (i % 5 == 4) ? 32'd0 : ((i % 2 == 0) ? $urandom() : 32'($urandom_range(1, 300)));
            if (i % 3 == 2) a = {{20{a[31]}}, a[11:0]};
            issue(i % 2, op, a, b, model(op, a, b), ((i % 2 == 1) && !op[1]) ? 1 : 33);
            wait_empty(i % 2, "random");
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mul_fast();
        test_div();
        test_mthi_cancel();
        test_back_to_back();
        test_reset_midrun();
        test_random();
        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end
endmodule
